// File: rtl/wishbone_reg_slave.sv
// wishbone_reg_slave: Wishbone slave register file with CONTROL, STATUS, ID,
// XFER_CNT and SCRATCH registers and a configurable number of wait states
// before each acknowledge.
// Optional feature macro: WB_REG_SLAVE_INT_EN enables INT_EN / INT_PEND and the
// wbs_int_o interrupt; when undefined the interrupt logic is absent.
module wishbone_reg_slave #(
  parameter int          ADDR_WIDTH  = 3,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h00001EAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic        wbs_msk_i,
  input  logic [3:0]  wbs_sel_i,
  output logic        wbs_ack_o,
  output logic        wbs_int_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] IDX_CTRL    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] IDX_STATUS  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ID      = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] IDX_XFER    = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] IDX_SCRATCH = ADDR_WIDTH'(4);

  // Wait counter start value; unused (held at 0) when there are no wait states.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       req;
  logic       commit;

  // Captured request fields.
  logic [31:0] adr_q, dat_q;
  logic        we_q;
  logic [3:0]  sel_q;

  // Register file.
  logic [31:0] ctrl_q;
  logic [31:0] xfer_q;
  logic [31:0] scratch_q [NUM_REGS];
  logic [31:0] dat_o_q;
  logic        int_pend;

  // Fields of the request being committed.
  logic [31:0]           cur_adr, cur_dat;
  logic                  cur_we;
  logic [3:0]            cur_sel;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic                  in_range;
  logic [31:0]           rd_val;
  logic [31:0]           ctrl_wdata;
  logic                  wr_ctrl, wr_scratch;

  // The mask input carries no meaning for this register file.
  logic unused_msk;
  assign unused_msk = wbs_msk_i;

  assign req = wbs_stb_i & wbs_cyc_i;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // State and wait-counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always_ff blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; commit marks the edge that enters ACK.
  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_HOLD;
      S_HOLD:  if (!wbs_stb_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
    end else if (state_q == S_IDLE && req) begin
      adr_q <= wbs_adr_i;
      dat_q <= wbs_dat_i;
      we_q  <= wbs_we_i;
      sel_q <= wbs_sel_i;
    end
  end

  // With no wait states the commit happens on the capture edge itself, so the
  // live bus fields are used while still in IDLE.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_adr = wbs_adr_i;
      cur_dat = wbs_dat_i;
      cur_we  = wbs_we_i;
      cur_sel = wbs_sel_i;
    end else begin
      cur_adr = adr_q;
      cur_dat = dat_q;
      cur_we  = we_q;
      cur_sel = sel_q;
    end
    cur_idx  = cur_adr[ADDR_WIDTH-1:0];
    in_range = (cur_adr[31:ADDR_WIDTH] == '0);
  end

  // Read mux; out-of-range addresses return zero.
  always_comb begin
    rd_val = '0;
    if (in_range) begin
      if (cur_idx >= IDX_SCRATCH) begin
        rd_val = scratch_q[cur_idx];
      end else begin
        case (cur_idx)
          IDX_CTRL:   rd_val = ctrl_q;
          IDX_STATUS: rd_val = {31'b0, int_pend};
          IDX_ID:     rd_val = ID_VALUE;
          IDX_XFER:   rd_val = xfer_q;
          default:    rd_val = '0;
        endcase
      end
    end
  end

  // Write decode and CONTROL write data.
  always_comb begin
    wr_ctrl    = commit & cur_we & in_range & (cur_idx == IDX_CTRL);
    wr_scratch = commit & cur_we & in_range & (cur_idx >= IDX_SCRATCH);
    ctrl_wdata = merge_bytes(ctrl_q, cur_dat, cur_sel);
`ifndef WB_REG_SLAVE_INT_EN
    ctrl_wdata[0] = 1'b0;
`endif
  end

  // Register file, transfer counter and registered read data.
  // NOTE: the scratch array is reset entry by entry because its reset value is
  // architecturally visible; a plain RAM without reset would read garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      xfer_q  <= '0;
      dat_o_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        scratch_q[i] <= '0;
      end
    end else if (commit) begin
      xfer_q  <= xfer_q + 32'd1;
      dat_o_q <= rd_val;
      if (wr_ctrl) begin
        ctrl_q <= ctrl_wdata;
      end
      if (wr_scratch) begin
        scratch_q[cur_idx] <= merge_bytes(scratch_q[cur_idx], cur_dat, cur_sel);
      end
    end
  end

`ifdef WB_REG_SLAVE_INT_EN
  logic pend_q, int_q;
  logic pend_set, pend_clr;

  assign pend_set = wr_scratch & ctrl_q[0];
  assign pend_clr = commit & cur_we & in_range & (cur_idx == IDX_STATUS) &
                    cur_sel[0] & cur_dat[0];
  assign int_pend = pend_q;

  // Pending flag (set wins over clear) and registered interrupt output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      pend_q <= pend_set | (pend_q & ~pend_clr);
      int_q  <= pend_q & ctrl_q[0];
    end
  end

  assign wbs_int_o = int_q;
`else
  assign int_pend  = 1'b0;
  assign wbs_int_o = 1'b0;
`endif

  assign wbs_ack_o = (state_q == S_ACK);
  assign wbs_dat_o = dat_o_q;

endmodule

// File: tb/tb_wishbone_reg_slave.sv
// Directed testbench for wishbone_reg_slave: one instance with one wait state
// and one with four, sharing the bus signals but with separate strobes.
module tb_wishbone_reg_slave;

`ifdef WB_REG_SLAVE_INT_EN
  localparam logic INT_ON = 1'b1;
`else
  localparam logic INT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        use4;
  logic [31:0] adr, wdat;
  logic        we, stb, cyc, msk;
  logic [3:0]  sel;
  logic        stb1, stb4;
  logic [31:0] dat1, dat4;
  logic        ack1, ack4, irq1, irq4;
  logic        cur_ack, cur_irq;
  logic [31:0] cur_dat;

  int n_cmp  = 0;
  int n_fail = 0;
  int acks1  = 0;

  assign stb1    = stb & ~use4;
  assign stb4    = stb & use4;
  assign cur_ack = use4 ? ack4 : ack1;
  assign cur_irq = use4 ? irq4 : irq1;
  assign cur_dat = use4 ? dat4 : dat1;

  wishbone_reg_slave #(.ADDR_WIDTH(3), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat1),
    .wbs_stb_i(stb1), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_msk_i(msk),
    .wbs_sel_i(sel), .wbs_ack_o(ack1), .wbs_int_o(irq1)
  );

  wishbone_reg_slave #(.ADDR_WIDTH(3), .WAIT_STATES(4)) dut4 (
    .clk(clk), .rst(rst), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat4),
    .wbs_stb_i(stb4), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_msk_i(msk),
    .wbs_sel_i(sel), .wbs_ack_o(ack4), .wbs_int_o(irq4)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transfer, started at a falling edge. Returns read data and latency
  // (falling edges from strobe to ack), the irq level in the ack cycle and one
  // cycle later. Leaves the slave back in IDLE.
  task automatic xfer(input logic use4_i, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [3:0] s, output logic [31:0] rdata,
                      output int lat, output logic irq_a, output logic irq_b);
    logic done;
    done  = 1'b0;
    lat   = 0;
    rdata = '0;
    irq_a = 1'b0;
    use4  = use4_i;
    adr   = a;
    wdat  = d;
    we    = w;
    sel   = s;
    stb   = 1'b1;
    cyc   = 1'b1;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (cur_ack) begin
        done  = 1'b1;
        lat   = i;
        rdata = cur_dat;
        irq_a = cur_irq;
      end
    end
    stb = 1'b0;
    cyc = 1'b0;
    we  = 1'b0;
    chk("ack_seen", 32'(done), 32'd1);
    if (done && !use4_i) acks1++;
    @(negedge clk);
    irq_b = cur_irq;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic use4_i, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] r;
    int          l;
    logic        ia, ib;
    xfer(use4_i, a, 32'h0, 1'b0, 4'hF, r, l, ia, ib);
    chk(tag, r, exp);
  endtask

  task automatic wr(input logic use4_i, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] r;
    int          l;
    logic        ia, ib;
    xfer(use4_i, a, d, 1'b1, s, r, l, ia, ib);
  endtask

  initial begin
    logic [31:0] r;
    int          lat, nack;
    logic        ia, ib, seen;

    rst  = 1'b1;
    use4 = 1'b0;
    adr  = '0;
    wdat = '0;
    we   = 1'b0;
    stb  = 1'b0;
    cyc  = 1'b0;
    msk  = 1'b0;
    sel  = 4'h0;

    // Reset values.
    #12;
    chk("rst_ack", 32'(ack1), 32'd0);
    chk("rst_dat", dat1, 32'h0);
    chk("rst_int", 32'(irq1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ID, write latency, readback, transfer count.
    rd_chk("id_read", 1'b0, 32'd2, 32'h00001EAF);
    rd_chk("ctrl_reset", 1'b0, 32'd0, 32'h0);
    xfer(1'b0, 32'd4, 32'hDEADBEEF, 1'b1, 4'hF, r, lat, ia, ib);
    chk("wr_latency", 32'(lat), 32'd2);
    xfer(1'b0, 32'd4, 32'h0, 1'b0, 4'hF, r, lat, ia, ib);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_addr4", r, 32'hDEADBEEF);
    rd_chk("xfer_cnt_a", 1'b0, 32'd3, 32'(acks1));

    // Byte enables.
    wr(1'b0, 32'd5, 32'h11223344, 4'hF);
    wr(1'b0, 32'd5, 32'hAABBCCDD, 4'b0101);
    rd_chk("byte_sel", 1'b0, 32'd5, 32'h11BB33DD);

    // Out of range: writes dropped (no aliasing), reads zero, still counted.
    wr(1'b0, 32'h00000104, 32'hCAFEF00D, 4'hF);
    rd_chk("oor_no_alias", 1'b0, 32'd4, 32'hDEADBEEF);
    rd_chk("oor_read", 1'b0, 32'h00000100, 32'h0);
    rd_chk("xfer_cnt_b", 1'b0, 32'd3, 32'(acks1));

    // Read-only registers ignore writes.
    wr(1'b0, 32'd2, 32'hFFFFFFFF, 4'hF);
    rd_chk("id_ro", 1'b0, 32'd2, 32'h00001EAF);
    wr(1'b0, 32'd3, 32'h12345678, 4'hF);
    rd_chk("xfer_ro", 1'b0, 32'd3, 32'(acks1));

    // Interrupt enable, set on SCRATCH write, clear via STATUS.
    wr(1'b0, 32'd0, 32'h80000001, 4'hF);
    rd_chk("ctrl_rd", 1'b0, 32'd0, INT_ON ? 32'h80000001 : 32'h80000000);
    xfer(1'b0, 32'd6, 32'h5A5A5A5A, 1'b1, 4'hF, r, lat, ia, ib);
    chk("irq_at_ack", 32'(ia), 32'd0);
    chk("irq_after_ack", 32'(ib), 32'(INT_ON));
    rd_chk("status_pend", 1'b0, 32'd1, 32'(INT_ON));
    xfer(1'b0, 32'd1, 32'h1, 1'b1, 4'b1110, r, lat, ia, ib);
    chk("irq_no_clr_sel", 32'(ib), 32'(INT_ON));
    xfer(1'b0, 32'd1, 32'h1, 1'b1, 4'b0001, r, lat, ia, ib);
    chk("irq_clr_ack", 32'(ia), 32'(INT_ON));
    chk("irq_clr_after", 32'(ib), 32'd0);
    rd_chk("status_clr", 1'b0, 32'd1, 32'h0);

    // Held strobe: exactly one ack, then a normal transfer.
    use4 = 1'b0;
    adr  = 32'd5;
    we   = 1'b0;
    sel  = 4'hF;
    stb  = 1'b1;
    cyc  = 1'b1;
    nack = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack1) begin
        seen = 1'b1;
        nack++;
      end
    end
    chk("held_ack_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack1) nack++;
    end
    stb = 1'b0;
    cyc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ack1) nack++;
    end
    chk("held_acks", 32'(nack), 32'd1);
    acks1++;
    xfer(1'b0, 32'd5, 32'h0, 1'b0, 4'hF, r, lat, ia, ib);
    chk("after_held_lat", 32'(lat), 32'd2);
    chk("after_held_dat", r, 32'h11BB33DD);

    // Raise the interrupt again so reset has something to clear.
    xfer(1'b0, 32'd7, 32'h0000_00FF, 1'b1, 4'hF, r, lat, ia, ib);
    chk("irq_reraise", 32'(ib), 32'(INT_ON));

    // Asynchronous reset while ack is high.
    use4 = 1'b0;
    adr  = 32'd4;
    we   = 1'b0;
    stb  = 1'b1;
    cyc  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack1) seen = 1'b1;
    end
    chk("pre_rst_ack", 32'(seen), 32'd1);
    chk("pre_rst_dat", dat1, 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ack", 32'(ack1), 32'd0);
    chk("async_rst_dat", dat1, 32'h0);
    chk("async_rst_int", 32'(irq1), 32'd0);
    @(negedge clk);
    stb = 1'b0;
    cyc = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    acks1 = 0;

    // Reset during WAIT of a write: no ack, nothing committed.
    adr  = 32'd7;
    wdat = 32'h12345678;
    we   = 1'b1;
    stb  = 1'b1;
    cyc  = 1'b1;
    @(negedge clk);
    chk("wait_no_ack", 32'(ack1), 32'd0);
    #2 rst = 1'b1;
    #2;
    chk("wait_rst_ack", 32'(ack1), 32'd0);
    @(negedge clk);
    stb = 1'b0;
    cyc = 1'b0;
    we  = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd_chk("post_rst_cnt", 1'b0, 32'd3, 32'h0);
    rd_chk("post_rst_id", 1'b0, 32'd2, 32'h00001EAF);
    rd_chk("post_rst_scr", 1'b0, 32'd7, 32'h0);
    rd_chk("post_rst_ctrl", 1'b0, 32'd0, 32'h0);

    // Four wait states: abort during WAIT, then out-of-range read.
    use4 = 1'b1;
    adr  = 32'd4;
    wdat = 32'hFEEDFACE;
    we   = 1'b1;
    sel  = 4'hF;
    stb  = 1'b1;
    cyc  = 1'b1;
    nack = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ack4) nack++;
    end
    stb = 1'b0;
    cyc = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack4) nack++;
    end
    chk("abort_acks", 32'(nack), 32'd0);
    rd_chk("abort_cnt", 1'b1, 32'd3, 32'h0);
    xfer(1'b1, 32'h00000100, 32'h0, 1'b0, 4'hF, r, lat, ia, ib);
    chk("ws4_latency", 32'(lat), 32'd5);
    chk("ws4_oor_dat", r, 32'h0);
    rd_chk("ws4_cnt", 1'b1, 32'd3, 32'd2);
    rd_chk("abort_no_commit", 1'b1, 32'd4, 32'h0);
    use4 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
